// File: rtl/tx_frame_sched.sv
// tx_frame_sched
// ----------------------------------------------------------------------------
// Frame-level scheduler that shares the Ethernet TX header chain between two
// AXI-Stream byte sources: src0 (UDP payload) and src1 (ARP reply request).
// Whole frames are granted round-robin. Header configuration is latched once
// per frame, and a fixed idle gap is enforced after each frame's last byte.
//
// Optional feature macro: TX_SCHED_LEN_CHECK_EN
//   Defined   - src0 frames are byte-counted. len_err pulses for one cycle
//               after a src0 tlast whose frame length differs from s0_len.
//   Undefined - no counter is built and len_err is tied low.
//
// Ports
//   s_axis_aclk                 sole clock
//   rst                         asynchronous active-high reset
//   s0_*  (tdata/tvalid/tready/tlast/tuser), s0_len   UDP payload source
//   s1_*  (tdata/tvalid/tready/tlast/tuser)           ARP request source
//   m_axis_* (tdata/tvalid/tready/tlast/tuser)        to header chain
//   udp_enable/ip_enable/arp_enable                   header inserter enables
//   eth_type, UDP_TotLen, IP_TotLen                   per-frame header fields
//   busy                        high in any state other than IDLE
//   len_err                     one-cycle length-mismatch pulse
// ----------------------------------------------------------------------------
module tx_frame_sched #(
    parameter int          IFG_CYCLES   = 12,
    parameter logic [15:0] ETH_TYPE_IP  = 16'h0800,
    parameter logic [15:0] ETH_TYPE_ARP = 16'h0806
) (
    input  logic        s_axis_aclk,
    input  logic        rst,
    input  logic [7:0]  s0_tdata,
    input  logic        s0_tvalid,
    output logic        s0_tready,
    input  logic        s0_tlast,
    input  logic        s0_tuser,
    input  logic [15:0] s0_len,
    input  logic [7:0]  s1_tdata,
    input  logic        s1_tvalid,
    output logic        s1_tready,
    input  logic        s1_tlast,
    input  logic        s1_tuser,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        udp_enable,
    output logic        ip_enable,
    output logic        arp_enable,
    output logic [15:0] eth_type,
    output logic [15:0] UDP_TotLen,
    output logic [15:0] IP_TotLen,
    output logic        busy,
    output logic        len_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_XFER,
        ST_GAP
    } state_t;

    // Wide enough to hold IFG_CYCLES-1.
    localparam int CNT_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   gap_cnt_reg, gap_cnt_next;
    logic               sel_reg;
    logic               last_grant_reg;
    logic               udp_enable_reg, ip_enable_reg, arp_enable_reg;
    logic [15:0]        eth_type_reg, udp_totlen_reg, ip_totlen_reg;

    logic               pick;
    logic               grant_load;
    logic               sel_tvalid, sel_tlast;
    logic               xfer_hs;

    // Round-robin pick: on a tie the source that did not win last time goes;
    // otherwise whichever source is valid.
    assign pick       = s1_tvalid & (~s0_tvalid | ~last_grant_reg);
    assign grant_load = (state_reg == ST_IDLE) && (s0_tvalid || s1_tvalid);

    assign sel_tvalid = sel_reg ? s1_tvalid : s0_tvalid;
    assign sel_tlast  = sel_reg ? s1_tlast  : s0_tlast;
    assign xfer_hs    = (state_reg == ST_XFER) && sel_tvalid && m_axis_tready;

    assign busy       = (state_reg != ST_IDLE);
    assign udp_enable = udp_enable_reg;
    assign ip_enable  = ip_enable_reg;
    assign arp_enable = arp_enable_reg;
    assign eth_type   = eth_type_reg;
    assign UDP_TotLen = udp_totlen_reg;
    assign IP_TotLen  = ip_totlen_reg;

    always_ff @(posedge s_axis_aclk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            gap_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        gap_cnt_next  = gap_cnt_reg;
        m_axis_tdata  = 8'h00;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s0_tready     = 1'b0;
        s1_tready     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (s0_tvalid || s1_tvalid) begin
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                state_next = ST_XFER;
            end
            ST_XFER: begin
                // Pure pass-through of the granted source; the other source
                // is held off until the frame's tlast handshake.
                if (sel_reg) begin
                    m_axis_tdata  = s1_tdata;
                    m_axis_tvalid = s1_tvalid;
                    m_axis_tlast  = s1_tlast;
                    m_axis_tuser  = s1_tuser;
                    s1_tready     = m_axis_tready;
                end else begin
                    m_axis_tdata  = s0_tdata;
                    m_axis_tvalid = s0_tvalid;
                    m_axis_tlast  = s0_tlast;
                    m_axis_tuser  = s0_tuser;
                    s0_tready     = m_axis_tready;
                end
                if (xfer_hs && sel_tlast) begin
                    if (IFG_CYCLES == 0) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next   = ST_GAP;
                        gap_cnt_next = CNT_W'(IFG_CYCLES - 1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Per-frame configuration is captured on the IDLE->GRANT edge so it is
    // already valid while in GRANT, and it is held until the next grant.
    always_ff @(posedge s_axis_aclk or posedge rst) begin
        if (rst) begin
            sel_reg        <= 1'b0;
            last_grant_reg <= 1'b1;
            udp_enable_reg <= 1'b0;
            ip_enable_reg  <= 1'b0;
            arp_enable_reg <= 1'b0;
            eth_type_reg   <= 16'h0000;
            udp_totlen_reg <= 16'h0000;
            ip_totlen_reg  <= 16'h0000;
        end else if (grant_load) begin
            sel_reg        <= pick;
            last_grant_reg <= pick;
            if (pick) begin
                udp_enable_reg <= 1'b0;
                ip_enable_reg  <= 1'b0;
                arp_enable_reg <= 1'b1;
                eth_type_reg   <= ETH_TYPE_ARP;
                udp_totlen_reg <= 16'h0000;
                ip_totlen_reg  <= 16'h0000;
            end else begin
                udp_enable_reg <= 1'b1;
                ip_enable_reg  <= 1'b1;
                arp_enable_reg <= 1'b0;
                eth_type_reg   <= ETH_TYPE_IP;
                // 16-bit modulo sums; oversize payloads wrap silently.
                udp_totlen_reg <= s0_len + 16'd8;
                ip_totlen_reg  <= s0_len + 16'd28;
            end
        end
    end

`ifdef TX_SCHED_LEN_CHECK_EN
    logic [15:0] byte_cnt_reg;
    logic [15:0] len_reg;
    logic        len_err_reg;

    always_ff @(posedge s_axis_aclk or posedge rst) begin
        if (rst) begin
            byte_cnt_reg <= 16'h0000;
            len_reg      <= 16'h0000;
            len_err_reg  <= 1'b0;
        end else begin
            len_err_reg <= 1'b0;
            if (grant_load) begin
                byte_cnt_reg <= 16'h0000;
                len_reg      <= s0_len;
            end else if (xfer_hs && !sel_reg) begin
                byte_cnt_reg <= byte_cnt_reg + 16'd1;
                // The tlast byte itself is not yet in the count.
                if (s0_tlast && ((byte_cnt_reg + 16'd1) != len_reg)) begin
                    len_err_reg <= 1'b1;
                end
            end
        end
    end

    assign len_err = len_err_reg;
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_tx_frame_sched.sv
// tb_tx_frame_sched
// Directed and randomized stimulus for tx_frame_sched. Expected behaviour is
// derived from frame-level timing rules: a decision in an idle cycle, config
// visible one cycle later, data two cycles later, and after a tlast handshake
// a gap of IFG cycles plus one idle cycle before the next decision.
`timescale 1ns/1ps
module tb_tx_frame_sched;
    localparam int IFG = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s0_tdata = '0, s1_tdata = '0, m_axis_tdata;
    logic        s0_tvalid = 1'b0, s0_tlast = 1'b0, s0_tuser = 1'b0, s0_tready;
    logic        s1_tvalid = 1'b0, s1_tlast = 1'b0, s1_tuser = 1'b0, s1_tready;
    logic [15:0] s0_len = '0;
    logic        m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast, m_axis_tuser;
    logic        udp_enable, ip_enable, arp_enable, busy, len_err;
    logic [15:0] eth_type, UDP_TotLen, IP_TotLen;

    tx_frame_sched #(.IFG_CYCLES(IFG)) dut (
        .s_axis_aclk(clk), .rst(rst),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
        .s0_tlast(s0_tlast), .s0_tuser(s0_tuser), .s0_len(s0_len),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
        .s1_tlast(s1_tlast), .s1_tuser(s1_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser),
        .udp_enable(udp_enable), .ip_enable(ip_enable), .arp_enable(arp_enable),
        .eth_type(eth_type), .UDP_TotLen(UDP_TotLen), .IP_TotLen(IP_TotLen),
        .busy(busy), .len_err(len_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Source byte queues: {tuser, tlast, tdata}
    logic [9:0] q0[$], q1[$], ref_q[$];
    logic [7:0] rx_q[$];
    int stall_pct = 0;
    int tready_mode = 0;  // 0: always 1, 1: toggle, 2: random
    logic tready_tgl = 1'b0;

    // Reference model state
    int   cyc_n = 0;
    bit   m_active = 0;
    int   m_sel = 0;
    int   m_last = 1;
    int   m_xfer_from = 0;
    int   m_avail = 0;
    int   m_bytes = 0;
    int   m_len = 0;
    int   m_lenerr_at = -1;
    int   frames_done = 0;
    int   order_q[$];
    int   lenerr_pulses = 0;
    logic busy_s = 1'b0;
    logic e_udp = 0, e_ip = 0, e_arp = 0;
    logic [15:0] e_type = '0, e_udplen = '0, e_iplen = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load0(input int nbytes, input int declared);
        logic [7:0] d;
        logic       u;
        for (int i = 0; i < nbytes; i++) begin
            d = 8'($urandom);
            u = (i == nbytes - 1) ? 1'($urandom) : 1'b0;
            q0.push_back({u, 1'(i == nbytes - 1), d});
        end
        s0_len = 16'(declared);
    endtask

    task automatic load1(input int nbytes);
        logic [7:0] d;
        for (int i = 0; i < nbytes; i++) begin
            d = 8'($urandom);
            q1.push_back({1'b0, 1'(i == nbytes - 1), d});
        end
    endtask

    task automatic drive();
        s0_tvalid = (q0.size() > 0) && !($urandom_range(99) < stall_pct);
        s1_tvalid = (q1.size() > 0) && !($urandom_range(99) < stall_pct);
        {s0_tuser, s0_tlast, s0_tdata} = (q0.size() > 0) ? q0[0] : 10'h0;
        {s1_tuser, s1_tlast, s1_tdata} = (q1.size() > 0) ? q1[0] : 10'h0;
        case (tready_mode)
            0: m_axis_tready = 1'b1;
            1: begin tready_tgl = ~tready_tgl; m_axis_tready = tready_tgl; end
            default: m_axis_tready = 1'($urandom_range(1));
        endcase
    endtask

    // One clock: check outputs at the negedge, advance the model, then
    // update sources just after the posedge.
    task automatic cyc();
        logic       ev;
        logic [9:0] head;
        bit         hs, pop0, pop1;
        @(negedge clk);
        cyc_n++;
        hs = 0; pop0 = 0; pop1 = 0; head = '0;
        busy_s = busy;
        if (len_err === 1'b1) lenerr_pulses++;
        if (m_active && cyc_n >= m_xfer_from) begin
            ev = (m_sel == 1) ? s1_tvalid : s0_tvalid;
            if (m_sel == 1) head = (q1.size() > 0) ? q1[0] : 10'h0;
            else            head = (q0.size() > 0) ? q0[0] : 10'h0;
            chk("m_tvalid", m_axis_tvalid, ev);
            if (ev) begin
                chk("m_tdata", m_axis_tdata, head[7:0]);
                chk("m_tlast", m_axis_tlast, head[8]);
                chk("m_tuser", m_axis_tuser, head[9]);
            end
            chk("s0_tready", s0_tready, (m_sel == 0) ? m_axis_tready : 1'b0);
            chk("s1_tready", s1_tready, (m_sel == 1) ? m_axis_tready : 1'b0);
            hs = ev && m_axis_tready;
        end else begin
            chk("m_tvalid_idle", m_axis_tvalid, 1'b0);
            chk("s0_tready_idle", s0_tready, 1'b0);
            chk("s1_tready_idle", s1_tready, 1'b0);
        end
        chk("busy", busy, m_active || (cyc_n < m_avail));
        chk("udp_enable", udp_enable, e_udp);
        chk("ip_enable", ip_enable, e_ip);
        chk("arp_enable", arp_enable, e_arp);
        chk("eth_type", eth_type, e_type);
        chk("udp_totlen", UDP_TotLen, e_udplen);
        chk("ip_totlen", IP_TotLen, e_iplen);
`ifdef TX_SCHED_LEN_CHECK_EN
        chk("len_err", len_err, cyc_n == m_lenerr_at);
`else
        chk("len_err", len_err, 1'b0);
`endif
        if (hs) begin
            rx_q.push_back(head[7:0]);
            m_bytes++;
            if (m_sel == 0) pop0 = 1; else pop1 = 1;
            if (head[8]) begin
                if (m_sel == 0 && (m_bytes % 65536) != m_len) m_lenerr_at = cyc_n + 1;
                m_active = 0;
                m_avail = cyc_n + IFG + 1;
                frames_done++;
            end
        end
        if (!m_active && cyc_n >= m_avail && (s0_tvalid || s1_tvalid)) begin
            if (s0_tvalid && s1_tvalid) m_sel = (m_last == 0) ? 1 : 0;
            else                        m_sel = s0_tvalid ? 0 : 1;
            m_last = m_sel;
            m_active = 1;
            m_xfer_from = cyc_n + 2;
            m_bytes = 0;
            order_q.push_back(m_sel);
            if (m_sel == 0) begin
                e_udp = 1; e_ip = 1; e_arp = 0; e_type = 16'h0800;
                e_udplen = s0_len + 16'd8; e_iplen = s0_len + 16'd28;
                m_len = s0_len;
            end else begin
                e_udp = 0; e_ip = 0; e_arp = 1; e_type = 16'h0806;
                e_udplen = 16'h0; e_iplen = 16'h0;
            end
        end
        @(posedge clk);
        #1;
        if (pop0) q0.delete(0);
        if (pop1) q1.delete(0);
        drive();
    endtask

    task automatic run_frames(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            cyc();
            n++;
        end
        chk(tag, frames_done, target);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_active) && n < 3000) begin
            cyc();
            n++;
        end
        chk(tag, (q0.size() > 0 || q1.size() > 0 || m_active), 1'b0);
    endtask

    // Asserts rst mid-cycle, checks the immediate (asynchronous) effect,
    // then releases it just after the next posedge.
    task automatic apply_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_m_tvalid"}, m_axis_tvalid, 1'b0);
        chk({tag, "_m_tdata"}, m_axis_tdata, 8'h00);
        chk({tag, "_m_tlast"}, m_axis_tlast, 1'b0);
        chk({tag, "_m_tuser"}, m_axis_tuser, 1'b0);
        chk({tag, "_s0_tready"}, s0_tready, 1'b0);
        chk({tag, "_s1_tready"}, s1_tready, 1'b0);
        chk({tag, "_udp_en"}, udp_enable, 1'b0);
        chk({tag, "_ip_en"}, ip_enable, 1'b0);
        chk({tag, "_arp_en"}, arp_enable, 1'b0);
        chk({tag, "_eth_type"}, eth_type, 16'h0);
        chk({tag, "_udp_len"}, UDP_TotLen, 16'h0);
        chk({tag, "_ip_len"}, IP_TotLen, 16'h0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_len_err"}, len_err, 1'b0);
        @(posedge clk);
        #1;
        q0.delete();
        q1.delete();
        rst = 1'b0;
        m_active = 0; m_last = 1; m_avail = cyc_n + 1; m_lenerr_at = -1;
        e_udp = 0; e_ip = 0; e_arp = 0; e_type = '0; e_udplen = '0; e_iplen = '0;
        drive();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n, p0, nb;
        @(posedge clk);
        #1;
        apply_reset("rst0");

        // 1: single 18-byte UDP frame
        rx_q.delete();
        load0(18, 18);
        drive();
        cyc();  // decision cycle; now in GRANT
        chk("t1_grant_udplen", UDP_TotLen, 16'd26);
        chk("t1_grant_iplen", IP_TotLen, 16'd46);
        chk("t1_grant_type", eth_type, 16'h0800);
        chk("t1_grant_en", {udp_enable, ip_enable, arp_enable}, 3'b110);
        chk("t1_grant_tvalid", m_axis_tvalid, 1'b0);
        run_frames(frames_done + 1, 200, "t1_frame_done");
        chk("t1_bytes", rx_q.size(), 18);
        n = 0;
        while (busy_s && n < 50) begin cyc(); n++; end
        chk("t1_busy_drop", n, IFG + 1);

        // 2: both sources valid out of reset, alternation over 4 frames
        apply_reset("rst1");
        base = order_q.size();
        load0(5, 5);
        load1(2);
        drive();
        for (int f = 0; f < 4; f++) begin
            run_frames(frames_done + 1, 300, "t2_frame_done");
            if (f == 1) begin
                chk("t2_arp_type", eth_type, 16'h0806);
                chk("t2_arp_en", {udp_enable, ip_enable, arp_enable}, 3'b001);
                chk("t2_arp_len", {UDP_TotLen, IP_TotLen}, 32'h0);
            end
            if (q0.size() == 0) load0(3 + f, 3 + f);
            if (q1.size() == 0) load1(1 + f);
            drive();
        end
        for (int f = 0; f < 4; f++) chk("t2_order", order_q[base + f], f % 2);
        drain("t2_drain");

        // 3: m_axis_tready toggling during a 10-byte src0 frame
        rx_q.delete();
        load0(10, 10);
        ref_q = q0;
        tready_mode = 1;
        drive();
        run_frames(frames_done + 1, 300, "t3_frame_done");
        chk("t3_count", rx_q.size(), 10);
        for (int i = 0; i < 10; i++) chk("t3_byte", rx_q[i], ref_q[i][7:0]);
        tready_mode = 0;
        drain("t3_drain");

        // 4: s1 becomes valid in the middle of a src0 frame
        base = order_q.size();
        load0(12, 12);
        drive();
        n = 0;
        while (!(m_active && m_bytes >= 3) && n < 200) begin cyc(); n++; end
        chk("t4_mid_frame", m_bytes >= 3, 1'b1);
        load1(2);
        drive();
        run_frames(frames_done + 2, 400, "t4_frames_done");
        chk("t4_first", order_q[base], 0);
        chk("t4_second", order_q[base + 1], 1);

        // 5: reset while the 5th of 20 bytes is on the bus
        load0(20, 20);
        drive();
        n = 0;
        while (!(m_active && m_bytes == 4) && n < 200) begin cyc(); n++; end
        chk("t5_reach_byte5", m_bytes, 4);
        #2;
        apply_reset("t5_rst");
        base = order_q.size();
        load0(3, 3);
        load1(2);
        drive();
        run_frames(frames_done + 1, 200, "t5_frame_done");
        chk("t5_first_after_rst", order_q[base], 0);
        drain("t5_drain");

        // 6: length check on a short frame and on a correct one
        p0 = lenerr_pulses;
        load0(9, 10);
        drive();
        run_frames(frames_done + 1, 200, "t6_short_done");
        repeat (3) cyc();
`ifdef TX_SCHED_LEN_CHECK_EN
        chk("t6_short_pulses", lenerr_pulses - p0, 1);
`else
        chk("t6_short_pulses", lenerr_pulses - p0, 0);
`endif
        p0 = lenerr_pulses;
        load0(10, 10);
        drive();
        run_frames(frames_done + 1, 200, "t6_ok_done");
        repeat (3) cyc();
        chk("t6_ok_pulses", lenerr_pulses - p0, 0);

        // 7: randomized traffic, stalls and backpressure
        stall_pct = 15;
        tready_mode = 2;
        for (int it = 0; it < 40; it++) begin
            if (q0.size() == 0 && $urandom_range(1) == 1) begin
                nb = $urandom_range(24, 1);
                load0(nb, ($urandom_range(3) == 0) ? nb + 1 : nb);
            end
            if (q1.size() == 0 && $urandom_range(2) == 0) load1($urandom_range(3, 1));
            drive();
            repeat ($urandom_range(30, 1)) cyc();
        end
        stall_pct = 0;
        drive();
        drain("t7_drain");
        repeat (IFG + 3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tx_frame_sched.md
Name: tx_frame_sched

Overview:
- Per-frame scheduler in front of the Ethernet TX header chain (ARP → UDP → IP → ETH inserters).
- Shares the chain between two AXI-Stream byte sources: src0 = UDP payload, src1 = ARP reply request.
- Grants one whole frame at a time with round-robin fairness. Latches per-frame header configuration (enables, eth_type, UDP/IP total lengths) and enforces a minimum idle gap between frames.

Parameters:
- IFG_CYCLES, 12, idle cycles in GAP after each frame's final handshake (0 = no gap).
- ETH_TYPE_IP, 16'h0800, eth_type driven for src0 frames.
- ETH_TYPE_ARP, 16'h0806, eth_type driven for src1 frames.

Ports:
- s_axis_aclk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- s0_tdata/s0_tvalid/s0_tready/s0_tlast/s0_tuser  in/in/out/in/in  8/1/1/1/1  UDP payload stream.
- s0_len  in  16  UDP payload byte count; sampled at grant, must be stable while s0_tvalid is high before grant.
- s1_tdata/s1_tvalid/s1_tready/s1_tlast/s1_tuser  in/in/out/in/in  8/1/1/1/1  ARP request stream (may be a 1-byte trigger).
- m_axis_tdata/m_axis_tvalid/m_axis_tready/m_axis_tlast/m_axis_tuser  out/out/in/out/out  8/1/1/1/1  to header chain.
- udp_enable, ip_enable, arp_enable  out  1 each  header inserter enables.
- eth_type  out  16  EtherType for current frame.
- UDP_TotLen, IP_TotLen  out  16 each  header length fields.
- busy  out  1  high in any state except IDLE.
- len_err  out  1  one-cycle pulse; see Optional Feature.

Behaviour:
- Reset values (async):
  - All outputs 0; eth_type = 0; state IDLE.
  - last_grant = 1, so src0 wins the first tie.
- States: IDLE, GRANT, XFER, GAP.
- IDLE:
  - Candidate = any source with tvalid high.
  - Both high → pick the source that is not last_grant; one high → pick it; none → stay.
  - s0_tready and s1_tready are 0 in IDLE, GRANT and GAP.
- GRANT (exactly 1 cycle):
  - Register sel and set last_grant = sel.
  - sel=0: udp_enable=1, ip_enable=1, arp_enable=0, eth_type=ETH_TYPE_IP, UDP_TotLen = s0_len+8, IP_TotLen = s0_len+28. Both sums are 16-bit modulo; s0_len > 65507 wraps and is not flagged.
  - sel=1: arp_enable=1, udp_enable=0, ip_enable=0, eth_type=ETH_TYPE_ARP, UDP_TotLen=0, IP_TotLen=0.
  - Config outputs hold from GRANT until the next GRANT. They are not cleared in GAP or IDLE.
- XFER:
  - Combinational pass-through of the selected source: m_axis_tdata/tvalid/tlast/tuser = selected s*; selected s*_tready = m_axis_tready; unselected tready = 0.
  - Transfer = m_axis_tvalid & m_axis_tready.
  - Transfer with tlast=1 → GAP, or IDLE directly if IFG_CYCLES=0.
  - The grant cannot change mid-frame, regardless of the other source's tvalid.
- GAP:
  - Counter loads IFG_CYCLES-1 on entry and decrements to 0, then → IDLE.
  - m_axis_tvalid=0 throughout GAP.
  - Minimum spacing, tlast handshake to the next frame's first m_axis_tvalid: IFG_CYCLES + 2 cycles (GAP + IDLE + GRANT).
- Boundaries:
  - Source deasserting tvalid mid-frame → hold in XFER, m_axis_tvalid=0.
  - tlast on the first byte is a legal 1-byte frame.
  - rst mid-frame → immediate return to reset values; the partially sent frame is abandoned. Downstream is reset by the same rst.

Optional Feature:
- Macro TX_SCHED_LEN_CHECK_EN.
- Defined:
  - 16-bit byte counter cleared at GRANT, incremented on each src0 XFER transfer.
  - On the src0 tlast transfer, if count+1 ≠ latched s0_len, pulse len_err for 1 cycle in the following cycle.
  - Frame still completes normally.
  - src1 frames are never checked.
- Undefined: counter absent; len_err tied 0.

Test Plan:
- Single UDP frame, s0_len=18, 18 bytes, m_axis_tready=1:
  - In GRANT: UDP_TotLen=26, IP_TotLen=46, eth_type=0x0800, udp/ip_enable=1, arp_enable=0.
  - 18 m_axis transfers; busy drops after 12 GAP cycles + tlast cycle.
- s0 and s1 both valid out of reset:
  - src0 frame first, then src1 frame (eth_type=0x0806, arp_enable=1, lengths 0).
  - Then with both still valid: src0 again (alternation verified over 4 frames).
- m_axis_tready toggled 1/0 every cycle during a 10-byte src0 frame:
  - All 10 bytes in order, no duplicates; s1_tready stays 0 throughout.
- s1 raises tvalid mid src0 frame:
  - No grant change until src0 tlast; s1 granted only after GAP.
- rst asserted on byte 5 of 20:
  - Same cycle: all outputs 0, busy=0.
  - After release, new frame granted from src0.
- TX_SCHED_LEN_CHECK_EN defined, s0_len=10, tlast on byte 9:
  - len_err = 1 for exactly 1 cycle.
  - With correct length (tlast on byte 10): len_err stays 0.
